nbit_pipe_register: RTL

- Parametrised successor to the plain N-bit register. A DEPTH-stage elastic pipeline of N-bit registers with a per-stage valid bit and valid/ready backpressure.
- Bubbles collapse, so a stalled output does not stall upstream stages that are empty.
- Sits between ALU operand/result paths and any stage that can back-pressure; replaces chains of bare registers where stalls must be absorbed.

---
 rtl/nbit_pipe_register_if.sv | 41 ++++
 rtl/nbit_pipe_register.sv | 83 ++++++++
 2 files changed

// File: rtl/nbit_pipe_register_if.sv
// nbit_pipe_register_if: valid/ready bus bundle for nbit_pipe_register.
// The flush signal exists only when PIPE_FLUSH_EN is defined.
// slave = the pipeline itself, master = the surrounding logic driving it.
interface nbit_pipe_register_if #(
  parameter int N     = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] occupancy;

`ifdef PIPE_FLUSH_EN
  logic          flush;

  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, occupancy
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );
`endif
endinterface

// File: rtl/nbit_pipe_register.sv
// nbit_pipe_register: DEPTH-stage elastic pipeline of N-bit registers with
// per-stage valid bits, valid/ready backpressure and bubble collapse.
// Stage 0 faces the input, stage DEPTH-1 drives the output.
// Optional synchronous flush is built in when PIPE_FLUSH_EN is defined.
module nbit_pipe_register #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  nbit_pipe_register_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [N-1:0]     d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    occ;
  logic             in_xfer;
  logic             out_xfer;
  logic             clr;

`ifdef PIPE_FLUSH_EN
  assign clr = bus.flush;
`else
  assign clr = 1'b0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Unrolled form of rdy[i] = !v[i] || rdy[i+1] with rdy[DEPTH] = out_ready:
    // a stage can load if the sink is ready or any stage at/after it is empty.
    // Written this way so each bit depends only on v and out_ready.
    assign rdy[i] = bus.out_ready || !(&v[DEPTH-1:i]);

    if (i == 0) begin : g_head
      // head stage: load from the upstream port whenever it can move
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v[0] <= 1'b0;
          d[0] <= '0;
        end else if (clr) begin
          v[0] <= 1'b0;
        end else if (rdy[0]) begin
          v[0] <= bus.in_valid;
          if (bus.in_valid) d[0] <= bus.in_data;
        end
      end
    end else begin : g_body
      // body stage: take the previous stage's word whenever it can move
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v[i] <= 1'b0;
          d[i] <= '0;
        end else if (clr) begin
          v[i] <= 1'b0;
        end else if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end
  end

  assign in_xfer  = bus.in_valid && rdy[0];
  assign out_xfer = v[DEPTH-1] && bus.out_ready;

  // occupancy tracks accepted minus delivered words; flush empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (clr) begin
      occ <= '0;
    end else begin
      occ <= occ + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.occupancy = occ;

endmodule
